pending_write_scoreboard: RTL and testbench
===========================================

Name: pending_write_scoreboard

Overview:
- Generalised pending-write scoreboard for the register-access stage.
- Keeps one saturating counter per architectural register of a class (segment, GPR, …), parametrised in register count, counter width and number of source read ports.
- Raises a decode stall when any valid source operand has an outstanding write, or when a new allocation would overflow its counter.
- Adds flush, saturation back-pressure, underflow error capture and an optional same-cycle retire bypass.

Parameters:
- NUM_REGS, 8, number of tracked registers; selects at or above NUM_REGS are untracked.
- SEL_WIDTH, 3, width of every register select; must satisfy 2^SEL_WIDTH >= NUM_REGS.
- CNT_WIDTH, 4, width of each pending counter; maximum count CMAX = 2^CNT_WIDTH-1.
- NUM_SRC, 2, number of source operand ports checked for hazards.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- alloc_valid, input, 1, the instruction in decode writes register alloc_sel.
- alloc_sel, input, SEL_WIDTH, destination register being allocated.
- advance, input, 1, next stage ready; the decode instruction leaves this cycle.
- retire_valid, input, 1, writeback completes a write to retire_sel.
- retire_sel, input, SEL_WIDTH, register being retired.
- src_valid, input, NUM_SRC, per-port "operand is a tracked register" qualifier.
- src_sel, input, NUM_SRC*SEL_WIDTH, packed source selects; port i occupies bits [i*SEL_WIDTH +: SEL_WIDTH].
- flush, input, 1, synchronous clear of all counters (pipeline flush).
- stall, output, 1, combinational hold request to decode.
- busy, output, NUM_REGS, registered; bit r = (count[r] != 0).
- underflow_err, output, 1, sticky flag: a retire arrived while its counter was 0.

Behaviour:
- Reset: all counters = 0, busy = 0, underflow_err = 0. stall = 0 whenever src_valid = 0 and alloc_valid = 0.
- Counter r updates at the clock edge:
  - inc_r = alloc_valid & advance & ~stall & (alloc_sel == r).
  - dec_r = retire_valid & (retire_sel == r) & (count[r] != 0). Retire is not gated by advance.
  - inc & dec together: no change. inc only: +1. dec only: -1. Neither: hold.
- Saturation:
  - full_hit = alloc_valid & (alloc_sel < NUM_REGS) & count[alloc_sel] == CMAX & ~(dec on the same register).
  - full_hit forces stall, so the counter never wraps.
- Hazard: src_hit_i = src_valid[i] & (src_sel_i < NUM_REGS) & (count[src_sel_i] != 0).
- stall = OR over i of src_hit_i, OR full_hit.
- Selects at or above NUM_REGS: never stall, never counted, never retire. A retire to such a select is a no-op with no error.
- Underflow: retire_valid with an in-range select whose count is 0 leaves the counter at 0 and sets underflow_err. The flag clears only on reset or flush.
- Flush: all counters, busy and underflow_err clear at the next edge. Flush has priority over inc and dec in the same cycle; stall is still evaluated from the current counts that cycle.
- busy reflects counters one cycle after each update. Counters hold when advance = 0 and no retire occurs.
- Latency: an allocation accepted in cycle N makes a dependent source stall from cycle N+1. A retire in cycle N clears the stall in cycle N+1 (without bypass).
- Reset asserted mid-operation clears state immediately (asynchronous); the first update after deassertion is at the next rising edge.

Optional Feature:
- Macro: SCOREBOARD_RETIRE_BYPASS_EN.
- Defined: src_hit_i is additionally masked when retire_valid & retire_sel == src_sel_i & count == 1 and no allocation to that register is accepted in that cycle. Writeback forwarding removes the one-cycle bubble.
- Undefined: stall is computed from registered counts only, exactly as in Behaviour.

Test Plan:
- Reset low for 2 cycles, then high; src_valid = 2'b11, src_sel = {3'd1, 3'd0} -> stall = 0, busy = 8'h00, underflow_err = 0.
- alloc_valid = 1, alloc_sel = 3, advance = 1 for 1 cycle; next cycle src0 = 3 -> stall = 1, busy[3] = 1. Then retire_sel = 3 -> stall = 0 next cycle (bypass off), or same cycle (bypass on).
- Same cycle alloc 3 with advance, and retire 3, while count[3] = 2 -> count stays 2, busy[3] stays 1.
- Allocate register 5 fifteen times (CMAX = 15); 16th alloc -> stall = 1, count holds at 15; retire 5 -> 16th alloc is accepted the next cycle.
- retire_valid = 1, retire_sel = 6 with count 0 -> underflow_err = 1 and stays 1; flush = 1 -> underflow_err = 0, busy = 8'h00 next cycle.
- src_sel = 3'd7 with NUM_REGS = 6 and alloc_sel = 7 -> stall never asserts, busy unchanged.

Source files
------------

// File: rtl/pending_write_scoreboard_if.sv
// Register-access stage bundle between decode/writeback and the pending-write scoreboard.
// The master side drives allocate/retire/source requests; the slave side returns stall, busy and error status.
interface pending_write_scoreboard_if #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_WIDTH = 3,
    parameter int NUM_SRC   = 2
);
    logic                           alloc_valid;
    logic [SEL_WIDTH-1:0]           alloc_sel;
    logic                           advance;
    logic                           retire_valid;
    logic [SEL_WIDTH-1:0]           retire_sel;
    logic [NUM_SRC-1:0]             src_valid;
    logic [NUM_SRC*SEL_WIDTH-1:0]   src_sel;
    logic                           flush;
    logic                           stall;
    logic [NUM_REGS-1:0]            busy;
    logic                           underflow_err;

    modport master (
        output alloc_valid, alloc_sel, advance, retire_valid, retire_sel,
               src_valid, src_sel, flush,
        input  stall, busy, underflow_err
    );

    modport slave (
        input  alloc_valid, alloc_sel, advance, retire_valid, retire_sel,
               src_valid, src_sel, flush,
        output stall, busy, underflow_err
    );
endinterface

// File: rtl/pending_write_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register, decode stall on RAW hazard or counter full.
// Optional same-cycle retire forwarding is enabled with the macro SCOREBOARD_RETIRE_BYPASS_EN.
module pending_write_scoreboard #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_WIDTH = 3,
    parameter int CNT_WIDTH = 4,
    parameter int NUM_SRC   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    pending_write_scoreboard_if.slave    sb
);

    localparam logic [CNT_WIDTH-1:0] CMAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;
    logic                 r_underflow;

    logic [CNT_WIDTH-1:0] w_count_nxt [NUM_REGS];
    logic [NUM_REGS-1:0]  w_alloc_oh;
    logic [NUM_REGS-1:0]  w_retire_oh;
    logic [NUM_REGS-1:0]  w_nonzero;
    logic [NUM_REGS-1:0]  w_is_one;
    logic [NUM_REGS-1:0]  w_is_max;
    logic [NUM_REGS-1:0]  w_dec;
    logic [NUM_REGS-1:0]  w_inc;
    logic [NUM_REGS-1:0]  w_alloc_try;
    logic [NUM_REGS-1:0]  w_bypass;
    logic [NUM_SRC-1:0]   w_src_hit;
    logic                 w_full_hit;
    logic                 w_stall;
    logic                 w_underflow_evt;

    // Selects at or above NUM_REGS decode to an all-zero one-hot, which makes
    // them untracked everywhere below without a separate range compare.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_alloc_oh[r]  = (sb.alloc_sel  == SEL_WIDTH'(r));
            w_retire_oh[r] = (sb.retire_sel == SEL_WIDTH'(r));
            w_nonzero[r]   = (r_count[r] != '0);
            w_is_one[r]    = (r_count[r] == CNT_ONE);
            w_is_max[r]    = (r_count[r] == CMAX);
        end
    end

    assign w_dec       = {NUM_REGS{sb.retire_valid}} & w_retire_oh & w_nonzero;
    assign w_alloc_try = {NUM_REGS{sb.alloc_valid & sb.advance}} & w_alloc_oh;

`ifdef SCOREBOARD_RETIRE_BYPASS_EN
    // Forward only the last outstanding write. Any attempted allocation to the
    // same register disables forwarding, which keeps stall free of a loop
    // through the accept term.
    assign w_bypass = w_dec & w_is_one & ~w_alloc_try;
`else
    assign w_bypass = '0;
`endif

    assign w_full_hit = sb.alloc_valid & (|(w_alloc_oh & w_is_max & ~w_dec));

    always_comb begin
        logic [SEL_WIDTH-1:0] v_sel;
        logic [NUM_REGS-1:0]  v_src_oh;
        for (int i = 0; i < NUM_SRC; i++) begin
            v_sel = sb.src_sel[i*SEL_WIDTH +: SEL_WIDTH];
            for (int r = 0; r < NUM_REGS; r++) begin
                v_src_oh[r] = (v_sel == SEL_WIDTH'(r));
            end
            w_src_hit[i] = sb.src_valid[i] & (|(v_src_oh & w_nonzero & ~w_bypass));
        end
    end

    assign w_stall         = w_full_hit | (|w_src_hit);
    assign w_inc           = w_alloc_try & {NUM_REGS{~w_stall}};
    assign w_underflow_evt = sb.retire_valid & (|(w_retire_oh & ~w_nonzero));

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_count_nxt[r] = r_count[r];
            if (sb.flush) begin
                w_count_nxt[r] = '0;
            end else if (w_inc[r] && !w_dec[r]) begin
                w_count_nxt[r] = r_count[r] + CNT_ONE;
            end else if (w_dec[r] && !w_inc[r]) begin
                w_count_nxt[r] = r_count[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_count[r] <= '0;
            end
            r_busy      <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_count[r] <= w_count_nxt[r];
                r_busy[r]  <= (w_count_nxt[r] != '0);
            end
            r_underflow <= sb.flush ? 1'b0 : (r_underflow | w_underflow_evt);
        end
    end

    assign sb.stall         = w_stall;
    assign sb.busy          = r_busy;
    assign sb.underflow_err = r_underflow;

endmodule

// File: tb/tb_pending_write_scoreboard.sv
// Bench for pending_write_scoreboard: directed test-plan steps plus random traffic, two instances
// (8 and 6 tracked registers) checked every cycle against an array-based reference model.
module tb_pending_write_scoreboard;

    localparam int CMAX = 15;

    logic       clk;
    logic       reset;
    logic       a_valid;
    logic [2:0] a_sel;
    logic       adv;
    logic       r_valid;
    logic [2:0] r_sel;
    logic [1:0] s_valid;
    logic [5:0] s_sel;
    logic       fl;

    int checks;
    int errors;
    int mcnt [2][8];
    bit merr [2];
    int nregs [2];

    pending_write_scoreboard_if #(.NUM_REGS(8), .SEL_WIDTH(3), .NUM_SRC(2)) if8 ();
    pending_write_scoreboard_if #(.NUM_REGS(6), .SEL_WIDTH(3), .NUM_SRC(2)) if6 ();

    assign if8.alloc_valid  = a_valid;
    assign if8.alloc_sel    = a_sel;
    assign if8.advance      = adv;
    assign if8.retire_valid = r_valid;
    assign if8.retire_sel   = r_sel;
    assign if8.src_valid    = s_valid;
    assign if8.src_sel      = s_sel;
    assign if8.flush        = fl;
    assign if6.alloc_valid  = a_valid;
    assign if6.alloc_sel    = a_sel;
    assign if6.advance      = adv;
    assign if6.retire_valid = r_valid;
    assign if6.retire_sel   = r_sel;
    assign if6.src_valid    = s_valid;
    assign if6.src_sel      = s_sel;
    assign if6.flush        = fl;

    pending_write_scoreboard #(.NUM_REGS(8), .SEL_WIDTH(3), .CNT_WIDTH(4), .NUM_SRC(2)) dut8 (
        .clk   (clk),
        .reset (reset),
        .sb    (if8.slave)
    );

    pending_write_scoreboard #(.NUM_REGS(6), .SEL_WIDTH(3), .CNT_WIDTH(4), .NUM_SRC(2)) dut6 (
        .clk   (clk),
        .reset (reset),
        .sb    (if6.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_stall(int k);
        bit st;
        int s;
        st = 0;
        if (a_valid && int'(a_sel) < nregs[k] && mcnt[k][a_sel] == CMAX &&
            !(r_valid && r_sel == a_sel))
            st = 1;
        for (int i = 0; i < 2; i++) begin
            s = int'(s_sel[i*3 +: 3]);
            if (s_valid[i] && s < nregs[k] && mcnt[k][s] != 0) begin
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
                if (!(r_valid && int'(r_sel) == s && mcnt[k][s] == 1 &&
                      !(a_valid && adv && int'(a_sel) == s)))
                    st = 1;
`else
                st = 1;
`endif
            end
        end
        return st;
    endfunction

    function automatic logic [31:0] model_busy(int k);
        logic [31:0] b;
        b = '0;
        for (int r = 0; r < nregs[k]; r++) b[r] = (mcnt[k][r] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) mcnt[k][r] = 0;
            merr[k] = 0;
        end
    endtask

    task automatic model_update();
        bit stl, dec;
        for (int k = 0; k < 2; k++) begin
            stl = model_stall(k);
            if (fl) begin
                for (int r = 0; r < 8; r++) mcnt[k][r] = 0;
                merr[k] = 0;
            end else begin
                dec = r_valid && int'(r_sel) < nregs[k] && mcnt[k][r_sel] != 0;
                if (r_valid && int'(r_sel) < nregs[k] && mcnt[k][r_sel] == 0) merr[k] = 1;
                if (a_valid && adv && !stl && int'(a_sel) < nregs[k]) mcnt[k][a_sel]++;
                if (dec) mcnt[k][r_sel]--;
            end
        end
    endtask

    task automatic check_outputs();
        chk("stall_n8", 32'(if8.stall), 32'(model_stall(0)));
        chk("busy_n8", 32'(if8.busy), model_busy(0));
        chk("uerr_n8", 32'(if8.underflow_err), 32'(merr[0]));
        chk("stall_n6", 32'(if6.stall), 32'(model_stall(1)));
        chk("busy_n6", 32'(if6.busy), model_busy(1));
        chk("uerr_n6", 32'(if6.underflow_err), 32'(merr[1]));
    endtask

    // Inputs are set by the caller just after a falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        a_valid = 0; a_sel = 0; adv = 0; r_valid = 0; r_sel = 0;
        s_valid = 0; s_sel = 0; fl = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nregs[0] = 8;
        nregs[1] = 6;
        model_reset();
        idle();
        reset = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;

        // reset state with both sources valid
        s_valid = 2'b11; s_sel = {3'd1, 3'd0};
        #1;
        chk("rst_stall", 32'(if8.stall), 32'd0);
        chk("rst_busy", 32'(if8.busy), 32'h00);
        chk("rst_uerr", 32'(if8.underflow_err), 32'd0);
        cycle();

        // allocate 3, then dependent source, then retire
        idle(); a_valid = 1; a_sel = 3; adv = 1; cycle();
        idle(); s_valid = 2'b01; s_sel = {3'd0, 3'd3};
        #1;
        chk("hazard_stall", 32'(if8.stall), 32'd1);
        chk("hazard_busy3", 32'(if8.busy[3]), 32'd1);
        cycle();
        r_valid = 1; r_sel = 3; cycle();
        r_valid = 0; cycle();

        // alloc+retire same register at count 2
        idle(); a_valid = 1; a_sel = 3; adv = 1; cycle(); cycle();
        r_valid = 1; r_sel = 3; cycle();
        idle(); #1; chk("incdec_busy3", 32'(if8.busy[3]), 32'd1); cycle();
        r_valid = 1; r_sel = 3; cycle(); cycle();
        idle(); cycle();

        // saturation of register 5
        a_valid = 1; a_sel = 5; adv = 1;
        for (int n = 0; n < 15; n++) cycle();
        #1; chk("sat_stall", 32'(if8.stall), 32'd1); cycle();
        cycle();
        idle(); r_valid = 1; r_sel = 5; cycle();
        idle(); a_valid = 1; a_sel = 5; adv = 1;
        #1; chk("sat_accept", 32'(if8.stall), 32'd0); cycle();
        #1; chk("sat_again", 32'(if8.stall), 32'd1); cycle();

        // underflow on register 6, sticky, then flush
        idle(); r_valid = 1; r_sel = 6; cycle();
        idle(); #1; chk("uerr_set", 32'(if8.underflow_err), 32'd1); cycle(); cycle();
        fl = 1; a_valid = 1; a_sel = 2; adv = 1; cycle();
        idle();
        #1;
        chk("flush_uerr", 32'(if8.underflow_err), 32'd0);
        chk("flush_busy", 32'(if8.busy), 32'h00);
        cycle();

        // select 7: untracked on the 6-register instance
        s_valid = 2'b11; s_sel = {3'd7, 3'd7}; a_valid = 1; a_sel = 7; adv = 1;
        for (int n = 0; n < 4; n++) cycle();
        r_valid = 1; r_sel = 7; a_valid = 0; cycle(); cycle(); cycle();
        idle(); fl = 1; cycle();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_sel   = 3'($urandom_range(0, 7));
            adv     = ($urandom_range(0, 3) != 0);
            r_valid = ($urandom_range(0, 2) == 0);
            r_sel   = 3'($urandom_range(0, 7));
            s_valid = 2'($urandom_range(0, 3));
            s_sel   = 6'($urandom_range(0, 63));
            fl      = ($urandom_range(0, 60) == 0);
            cycle();
        end

        // asynchronous reset in the middle of a cycle
        idle(); a_valid = 1; a_sel = 4; adv = 1; cycle(); cycle();
        idle(); s_valid = 2'b11; s_sel = {3'd4, 3'd4};
        #2;
        reset = 0;
        #1;
        chk("arst_busy", 32'(if8.busy), 32'h00);
        chk("arst_stall", 32'(if8.stall), 32'd0);
        chk("arst_uerr", 32'(if6.underflow_err), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1;
        a_valid = 1; a_sel = 4; adv = 1; cycle();
        idle(); s_valid = 2'b10; s_sel = {3'd4, 3'd0}; cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
